rect_sum_unit: RTL and testbench

Evaluates one Haar rectangle of a cascade feature. It takes a 20-bit rectangle descriptor, as delivered by the rect1/rect2/rect3 descriptor ROMs, together with that rectangle's signed weight. It fetches the four corner values from the integral-image window buffer and returns the weighted rectangle sum to the feature accumulator. It sits between the feature sequencer/descriptor ROMs (upstream) and the feature-sum/threshold stage (downstream).

---
 rtl/rect_sum_unit.sv | 161 ++++++++++++++++
 tb/tb_rect_sum_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_sum_unit.sv
`default_nettype none
// ============================================================================
// Module   : rect_sum_unit
// Brief    : Weighted Haar rectangle sum from four integral-image corner reads.
// Revision : 1.0 - initial release
// ============================================================================
module rect_sum_unit #(
    parameter int W_DATA   = 20,
    parameter int W_COORD  = 5,
    parameter int W_WIN    = 25,
    parameter int W_II     = 18,
    parameter int W_IIADDR = 10,
    parameter int W_WEIGHT = 4,
    parameter int W_OUT    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_DATA-1:0]   in_rect,
    input  logic [W_WEIGHT-1:0] in_weight,
    output logic                ii_en,
    output logic [W_IIADDR-1:0] ii_addr,
    input  logic [W_II-1:0]     ii_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W_OUT-1:0]    out_sum,
    output logic                out_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_RD_C = 3'd3,
        S_RD_D = 3'd4,
        S_ACC  = 3'd5,
        S_MUL  = 3'd6,
        S_OUT  = 3'd7
    } state_t;

    localparam logic [W_COORD:0] C_LIMIT = (W_COORD+1)'(W_WIN - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [W_DATA-1:0]           r_rect;
    logic [W_WEIGHT-1:0]         r_weight;
    logic signed [W_II+1:0]      r_acc;
    logic                        r_ii_en;
    logic [W_IIADDR-1:0]         r_ii_addr;
    logic [W_OUT-1:0]            r_sum;
    logic                        r_err;

    logic [W_DATA-1:0]           w_src;
    logic [W_COORD:0]            w_x, w_y, w_w, w_h, w_xw, w_yh;
    logic                        w_null, w_oob, w_accept, w_rd_next;
    logic [W_COORD:0]            w_row, w_col;
    logic [W_IIADDR-1:0]         w_row_ext, w_addr;
    logic signed [W_II+1:0]      w_ii_ext;
    logic signed [W_OUT-1:0]     w_prod;

    // While idle the live descriptor drives the A address; afterwards the captured one.
    assign w_src = (r_state == S_IDLE) ? in_rect : r_rect;
    assign w_x   = {1'b0, w_src[4*W_COORD-1 -: W_COORD]};
    assign w_y   = {1'b0, w_src[3*W_COORD-1 -: W_COORD]};
    assign w_w   = {1'b0, w_src[2*W_COORD-1 -: W_COORD]};
    assign w_h   = {1'b0, w_src[W_COORD-1:0]};
    assign w_xw  = w_x + w_w;
    assign w_yh  = w_y + w_h;

    assign w_null    = (w_w == '0) || (w_h == '0);
    assign w_oob     = (w_xw > C_LIMIT) || (w_yh > C_LIMIT);
    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_rd_next = (w_next == S_RD_A) || (w_next == S_RD_B) ||
                       (w_next == S_RD_C) || (w_next == S_RD_D);

    always_comb begin
        w_row = w_y;
        w_col = w_x;
        case (w_next)
            S_RD_B:  w_col = w_xw;
            S_RD_C:  w_row = w_yh;
            S_RD_D: begin
                w_row = w_yh;
                w_col = w_xw;
            end
            default: ;
        endcase
    end

    // row * 25 as (row<<4) + (row<<3) + row
    assign w_row_ext = W_IIADDR'(w_row);
    assign w_addr    = (w_row_ext << 4) + (w_row_ext << 3) + w_row_ext + W_IIADDR'(w_col);

    assign w_ii_ext = $signed({2'b00, ii_data});
    // The accumulator is non-negative here, so sign-extending it equals
    // zero-extending its low W_II bits.
    assign w_prod = W_OUT'(r_acc) * {{(W_OUT-W_WEIGHT){r_weight[W_WEIGHT-1]}}, r_weight};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Null/out-of-window rects pass through MUL (acc cleared) for a 1-cycle latency.
                if (in_valid) w_next = (w_null || w_oob) ? S_MUL : S_RD_A;
            end
            S_RD_A:  w_next = S_RD_B;
            S_RD_B:  w_next = S_RD_C;
            S_RD_C:  w_next = S_RD_D;
            S_RD_D:  w_next = S_ACC;
            S_ACC:   w_next = S_MUL;
            S_MUL:   w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rect    <= '0;
            r_weight  <= '0;
            r_acc     <= '0;
            r_ii_en   <= 1'b0;
            r_ii_addr <= '0;
            r_sum     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rect   <= in_rect;
                r_weight <= in_weight;
                r_acc    <= '0;
                r_err    <= !w_null && w_oob;
            end
            r_ii_en <= w_rd_next;
            if (w_rd_next) r_ii_addr <= w_addr;
            // Read data lands one state after its request: A..D return in RD_B..ACC.
            case (r_state)
                S_RD_B:  r_acc <= w_ii_ext;
                S_RD_C:  r_acc <= r_acc - w_ii_ext;
                S_RD_D:  r_acc <= r_acc - w_ii_ext;
                S_ACC:   r_acc <= r_acc + w_ii_ext;
                S_MUL:   r_sum <= w_prod;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign ii_en     = r_ii_en;
    assign ii_addr   = r_ii_addr;
    assign out_sum   = r_sum;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rect_sum_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_sum_unit
// Brief    : Self-checking bench; integral image built from a pixel array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_sum_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_rect;
    logic [3:0]  in_weight;
    logic        ii_en;
    logic [9:0]  ii_addr;
    logic [17:0] ii_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_sum;
    logic        out_err;

    int errors = 0;
    int checks = 0;

    int          pix [24][24];
    logic [17:0] mem [625];
    int          rd_q [$];

    rect_sum_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rect   (in_rect),
        .in_weight (in_weight),
        .ii_en     (ii_en),
        .ii_addr   (ii_addr),
        .ii_data   (ii_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Window buffer: one-cycle read latency, every request logged.
    always @(posedge clk) begin
        if (ii_en) begin
            ii_data <= (ii_addr < 10'd625) ? mem[ii_addr] : 18'h0;
            rd_q.push_back(int'(ii_addr));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_ii();
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < 25; c++) begin
                int s;
                s = 0;
                for (int rr = 0; rr < r; rr++)
                    for (int cc = 0; cc < c; cc++)
                        s += pix[rr][cc];
                mem[r*25+c] = 18'(s);
            end
        end
    endtask

    task automatic run_rect(input logic [19:0] rect, input logic [3:0] wt, input int hold);
        int x, y, w, h, s, lat, cnt;
        logic [21:0] exp_sum;
        logic        exp_err;
        int          exp_addr [$];
        x = int'(rect[19:15]);
        y = int'(rect[14:10]);
        w = int'(rect[9:5]);
        h = int'(rect[4:0]);
        exp_sum = '0;
        exp_err = 1'b0;
        lat     = 1;
        if (w == 0 || h == 0) begin
            exp_err = 1'b0;
        end else if (x + w > 24 || y + h > 24) begin
            exp_err = 1'b1;
        end else begin
            s = 0;
            for (int r = y; r < y + h; r++)
                for (int c = x; c < x + w; c++)
                    s += pix[r][c];
            exp_sum = 22'(s * int'($signed(wt)));
            exp_addr = '{y*25+x, y*25+x+w, (y+h)*25+x, (y+h)*25+x+w};
            lat = 6;
        end

        @(negedge clk);
        rd_q.delete();
        in_rect   = rect;
        in_weight = wt;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(lat));
        chk("out_sum", 32'(out_sum), 32'(exp_sum));
        chk("out_err", 32'(out_err), 32'(exp_err));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(exp_sum));
            chk("hold_err", 32'(out_err), 32'(exp_err));
            chk("hold_busy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_hs", 32'(in_ready), 32'd1);
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("read_count", 32'(rd_q.size()), 32'(exp_addr.size()));
        if (rd_q.size() == exp_addr.size())
            foreach (exp_addr[i]) chk("read_addr", 32'(rd_q[i]), 32'(exp_addr[i]));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rect   = '0;
        in_weight = '0;
        out_ready = 1'b1;
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                pix[r][c] = 1;
        build_ii();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ii_en", 32'(ii_en), 32'd0);
        chk("rst_ii_addr", 32'(ii_addr), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);

        // ii[r][c] = r*c image
        run_rect(20'h10c85, 4'd2, 0);
        run_rect(20'h10c85, 4'hF, 10);
        run_rect(20'h10c85, 4'h8, 1);
        run_rect(20'h00000, 4'd5, 0);
        run_rect({5'd20, 5'd0, 5'd5, 5'd1}, 4'd3, 2);
        run_rect({5'd0, 5'd20, 5'd1, 5'd5}, 4'd3, 0);
        run_rect({5'd19, 5'd19, 5'd5, 5'd5}, 4'd7, 0);
        run_rect({5'd0, 5'd0, 5'd24, 5'd24}, 4'd1, 0);

        // Reset while the C corner is being requested
        @(negedge clk);
        in_rect   = 20'h10c85;
        in_weight = 4'd2;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ii_en", 32'(ii_en), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_rect(20'h10c85, 4'd3, 0);

        // Random pixel image, random rectangles
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                pix[r][c] = int'($urandom_range(0, 255));
        build_ii();
        for (int i = 0; i < 30; i++) begin
            int x, y, w, h;
            logic [19:0] rr;
            if (i % 6 == 5) begin
                rr = 20'($urandom);
            end else begin
                x  = int'($urandom_range(0, 23));
                y  = int'($urandom_range(0, 23));
                w  = int'($urandom_range(1, 24 - x));
                h  = int'($urandom_range(1, 24 - y));
                rr = {5'(x), 5'(y), 5'(w), 5'(h)};
            end
            run_rect(rr, 4'($urandom), int'($urandom_range(0, 3)));
        end
        run_rect({5'd0, 5'd0, 5'd24, 5'd24}, 4'h8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
